// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory port arbiter.
// State/owner enums, default memory latency, bus widths.
package mem_arb_pkg;

  localparam int unsigned MEM_LAT_DEF = 2;
  localparam int unsigned AW          = 32;
  localparam int unsigned DW          = 32;
  localparam int unsigned CNT_W       = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } owner_e;

endpackage

// File: rtl/mem_port_arbiter_arb_pick.sv
// arb_pick: combinational winner between fetch and data requests.
// Ports: if_req_i, d_req_i -> owner_o; with ARB_ROUND_ROBIN_EN also
// clk_i, rst_i, take_i (grant taken) driving the round-robin pointer.
module arb_pick
  import mem_arb_pkg::*;
(
`ifdef ARB_ROUND_ROBIN_EN
  input  logic   clk_i,
  input  logic   rst_i,
  input  logic   take_i,
`endif
  input  logic   if_req_i,
  input  logic   d_req_i,
  output owner_e owner_o
);

`ifdef ARB_ROUND_ROBIN_EN
  // ptr_q = 1 means data wins the next contested grant
  logic ptr_q;
  logic ptr_d;
  logic both;

  assign both = if_req_i & d_req_i;

  always_comb begin
    ptr_d = ptr_q;
    if (take_i && both) begin
      ptr_d = ~ptr_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr_q <= 1'b1;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  always_comb begin
    if (both) begin
      owner_o = ptr_q ? OWN_D : OWN_IF;
    end else begin
      owner_o = d_req_i ? OWN_D : OWN_IF;
    end
  end
`else
  // Value with no request at all is ignored by the caller
  assign owner_o = (d_req_i || !if_req_i) ? OWN_D : OWN_IF;
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates fetch and data ports onto one single-port memory.
// Ports: clk, rst (sync, high); if_* fetch port; d_* data port;
// mem_* memory side. Parameter MEM_LAT (1..4) is the read latency.
// Macro ARB_ROUND_ROBIN_EN: alternate winner on contested requests.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned MEM_LAT = MEM_LAT_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_gnt,
  output logic          if_rvalid,
  output logic [DW-1:0] if_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_gnt,
  output logic          d_rvalid,
  output logic [DW-1:0] d_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  state_e           state_q, state_d;
  owner_e           own_q, own_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [AW-1:0]    addr_q, addr_d;
  logic [DW-1:0]    wdata_q, wdata_d;
  logic             we_q, we_d;
  logic             take;
  owner_e           pick;

  arb_pick u_pick (
`ifdef ARB_ROUND_ROBIN_EN
    .clk_i    (clk),
    .rst_i    (rst),
    .take_i   (take),
`endif
    .if_req_i (if_req),
    .d_req_i  (d_req),
    .owner_o  (pick)
  );

  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

  always_comb begin
    state_d   = state_q;
    own_d     = own_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    we_d      = we_q;
    take      = 1'b0;
    if_gnt    = 1'b0;
    d_gnt     = 1'b0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    if_rvalid = 1'b0;
    d_rvalid  = 1'b0;
    if_rdata  = '0;
    d_rdata   = '0;
    // Outputs are held quiet for the whole reset cycle
    if (!rst) begin
      unique case (state_q)
        IDLE: begin
          if (if_req || d_req) begin
            take    = 1'b1;
            state_d = ISSUE;
            own_d   = pick;
            if (pick == OWN_D) begin
              d_gnt   = 1'b1;
              addr_d  = d_addr;
              we_d    = d_we;
              wdata_d = d_wdata;
            end else begin
              if_gnt  = 1'b1;
              addr_d  = if_addr;
              we_d    = 1'b0;
              wdata_d = '0;
            end
          end
        end
        ISSUE: begin
          mem_en  = 1'b1;
          mem_we  = we_q;
          cnt_d   = CNT_W'(MEM_LAT - 1);
          state_d = (MEM_LAT == 1) ? RESP : WAIT;
        end
        WAIT: begin
          if (cnt_q > CNT_W'(1)) begin
            cnt_d = cnt_q - CNT_W'(1);
          end else begin
            state_d = RESP;
          end
        end
        RESP: begin
          state_d = IDLE;
          if (own_q == OWN_D) begin
            d_rvalid = 1'b1;
            d_rdata  = we_q ? '0 : mem_rdata;
          end else begin
            if_rvalid = 1'b1;
            if_rdata  = mem_rdata;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      own_q   <= OWN_IF;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      own_q   <= own_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
    end
  end

endmodule
